// File: rtl/mem_store_buffer.sv
// Store buffer between a core and data memory. Stores are queued in a
// circular FIFO, drained to memory in program order, and younger loads
// can pick up pending store data through the combinational forward path.
module mem_store_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          memwrite,
   input  logic [AW-1:0] dataadr,
   input  logic [31:0]   writedata,
   output logic          stall,
   output logic          fwd_hit,
   output logic [31:0]   fwd_data,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic          mem_ack,
   output logic          empty
);

   localparam int unsigned PW  = $clog2(DEPTH);
   localparam int unsigned CW  = PW + 1;
   localparam int unsigned WAW = AW - 2;

   typedef enum logic {
      st_idle = 1'b0,
      st_req  = 1'b1
   } state_t;

   state_t              state;
   state_t              state_d;
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [PW-1:0]       rd_next;
   logic [CW-1:0]       count;
   logic [CW-1:0]       count_d;
   logic                push;
   logic                pop;
   logic                mem_req_d;
   logic [AW-1:0]       mem_addr_d;
   logic [31:0]         mem_wdata_d;
   logic [WAW-1:0]      ent_addr [DEPTH];
   logic [31:0]         ent_data [DEPTH];
   logic [PW-1:0]       fwd_idx;
   logic                unused_bits;

   // Byte offset within the word plays no part in matching or storage.
   assign unused_bits = &{1'b0, dataadr[1:0]};

   assign stall   = (count == CW'(DEPTH));
   assign empty   = (count == '0) && (state == st_idle);
   assign push    = memwrite && !stall;
   assign pop     = (state == st_req) && mem_ack;
   assign rd_next = rd_ptr + PW'(1);
   assign count_d = count + CW'(push) - CW'(pop);

   // Entry storage; validity comes from count, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         ent_addr[wr_ptr] <= dataadr[AW-1:2];
         ent_data[wr_ptr] <= writedata;
      end
   end

   // Pointers, occupancy, drain state and registered memory request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         state     <= st_idle;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_next;
         count     <= count_d;
         state     <= state_d;
         mem_req   <= mem_req_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
      end
   end

   // Drain FSM: present the oldest entry, advance on ack. When the only
   // remaining entry is the one being pushed this cycle, take it straight
   // from the core inputs since storage is not yet written.
   always_comb begin
      state_d     = state;
      mem_req_d   = mem_req;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      case (state)
         st_idle: begin
            if (count != '0) begin
               state_d     = st_req;
               mem_req_d   = 1'b1;
               mem_addr_d  = {ent_addr[rd_ptr], 2'b00};
               mem_wdata_d = ent_data[rd_ptr];
            end
         end
         st_req: begin
            if (mem_ack) begin
               if (count_d == '0) begin
                  state_d   = st_idle;
                  mem_req_d = 1'b0;
               end else if (count == CW'(1)) begin
                  mem_addr_d  = {dataadr[AW-1:2], 2'b00};
                  mem_wdata_d = writedata;
               end else begin
                  mem_addr_d  = {ent_addr[rd_next], 2'b00};
                  mem_wdata_d = ent_data[rd_next];
               end
            end
         end
         default: begin
            state_d   = st_idle;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // Forward lookup: walk entries oldest to youngest so the youngest match wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_idx  = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         fwd_idx = rd_ptr + PW'(k);
         if ((CW'(k) < count) && (ent_addr[fwd_idx] == dataadr[AW-1:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = ent_data[fwd_idx];
         end
      end
   end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer: reset, single store, fill/drain,
// forwarding, full with simultaneous pop/push, wrap-around, mid-request reset.
module tb_mem_store_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        memwrite = 1'b0;
   logic [31:0] dataadr = '0;
   logic [31:0] writedata = '0;
   logic        mem_ack = 1'b0;
   logic        stall;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        empty;

   int errors = 0;
   int checks = 0;

   logic [31:0] wq_addr[$];
   logic [31:0] wq_data[$];

   mem_store_buffer #(.DEPTH(4), .AW(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .memwrite  (memwrite),
      .dataadr   (dataadr),
      .writedata (writedata),
      .stall     (stall),
      .fwd_hit   (fwd_hit),
      .fwd_data  (fwd_data),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .empty     (empty)
   );

   always #5 clk = ~clk;

   // Record each accepted memory write at the falling edge before it is taken.
   always @(negedge clk) begin
      if (rst && mem_req && mem_ack) begin
         wq_addr.push_back(mem_addr);
         wq_data.push_back(mem_wdata);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [31:0] a, input logic [31:0] d);
      memwrite  = 1'b1;
      dataadr   = a;
      writedata = d;
      step();
      memwrite  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      step();
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", empty); end
      checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd_hit got=%0b exp=0", fwd_hit); end
      checks++; if (fwd_data !== 32'h0) begin errors++; $display("FAIL reset_fwd_data got=%h exp=0", fwd_data); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
      checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
   endtask

   task automatic test_single();
      wq_addr.delete(); wq_data.delete();
      mem_ack = 1'b1;
      push_one(32'h0000_0054, 32'h0000_0007);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL single_req_early got=%0b exp=0", mem_req); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_not_empty got=%0b exp=0", empty); end
      step();
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL single_req got=%0b exp=1", mem_req); end
      checks++; if (mem_addr !== 32'h54) begin errors++; $display("FAIL single_addr got=%h exp=54", mem_addr); end
      checks++; if (mem_wdata !== 32'h7) begin errors++; $display("FAIL single_wdata got=%h exp=7", mem_wdata); end
      step();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL single_req_drop got=%0b exp=0", mem_req); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty got=%0b exp=1", empty); end
      checks++; if (wq_addr.size() !== 1) begin errors++; $display("FAIL single_writes got=%0d exp=1", wq_addr.size()); end
      mem_ack = 1'b0;
   endtask

   task automatic test_fill_drain();
      wq_addr.delete(); wq_data.delete();
      mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) push_one(32'h10 + 32'(4 * i), 32'(i + 1));
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fill_stall got=%0b exp=1", stall); end
      push_one(32'h30, 32'h5);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fill_stall_hold got=%0b exp=1", stall); end
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fill_req got=%0b exp=1", mem_req); end
      checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL fill_addr got=%h exp=10", mem_addr); end
      checks++; if (mem_wdata !== 32'h1) begin errors++; $display("FAIL fill_wdata got=%h exp=1", mem_wdata); end
      mem_ack = 1'b1;
      repeat (4) step();
      mem_ack = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%0b exp=1", empty); end
      checks++; if (wq_addr.size() !== 4) begin errors++; $display("FAIL drain_count got=%0d exp=4", wq_addr.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < wq_addr.size()) begin
            checks++;
            if (wq_addr[i] !== 32'h10 + 32'(4 * i) || wq_data[i] !== 32'(i + 1)) begin
               errors++;
               $display("FAIL drain_order[%0d] got=%h/%h exp=%h/%h", i, wq_addr[i], wq_data[i], 32'h10 + 32'(4 * i), 32'(i + 1));
            end
         end
      end
   endtask

   task automatic test_forward();
      wq_addr.delete(); wq_data.delete();
      mem_ack = 1'b0;
      push_one(32'h20, 32'hA);
      push_one(32'h20, 32'hB);
      push_one(32'h28, 32'hC);
      dataadr = 32'h22; #1;
      checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hB) begin errors++; $display("FAIL fwd_young got=%0b/%h exp=1/b", fwd_hit, fwd_data); end
      dataadr = 32'h24; #1;
      checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin errors++; $display("FAIL fwd_miss got=%0b/%h exp=0/0", fwd_hit, fwd_data); end
      dataadr = 32'h2B; #1;
      checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hC) begin errors++; $display("FAIL fwd_other got=%0b/%h exp=1/c", fwd_hit, fwd_data); end
      mem_ack = 1'b1;
      for (int i = 0; i < 20 && !empty; i++) step();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fwd_drain_timeout empty=%0b exp=1", empty); end
      checks++; if (wq_addr.size() !== 3) begin errors++; $display("FAIL fwd_no_coalesce got=%0d exp=3", wq_addr.size()); end
      // Entry being popped this edge still forwards.
      push_one(32'h40, 32'hD);
      step();
      checks++; if (mem_req !== 1'b1 || fwd_hit !== 1'b1 || fwd_data !== 32'hD) begin
         errors++; $display("FAIL fwd_pop_edge got=req%0b/%0b/%h exp=req1/1/d", mem_req, fwd_hit, fwd_data); end
      step();
      checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin errors++; $display("FAIL fwd_after_pop got=%0b/%h exp=0/0", fwd_hit, fwd_data); end
      mem_ack = 1'b0;
   endtask

   task automatic test_full_pop_push();
      logic [31:0] ea [5];
      logic [31:0] ed [5];
      ea = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h204};
      ed = '{32'h21, 32'h22, 32'h23, 32'h24, 32'h66};
      wq_addr.delete(); wq_data.delete();
      mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) push_one(32'h100 + 32'(4 * i), 32'h21 + 32'(i));
      mem_ack = 1'b1; memwrite = 1'b1; dataadr = 32'h200; writedata = 32'h55; #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall got=%0b exp=1", stall); end
      step();
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_after_pop got=%0b exp=0", stall); end
      memwrite = 1'b0; #1;
      checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL full_refused_fwd got=%0b exp=0", fwd_hit); end
      memwrite = 1'b1; dataadr = 32'h204; writedata = 32'h66;
      step();
      memwrite = 1'b0;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_push_pop_stall got=%0b exp=0", stall); end
      for (int i = 0; i < 20 && !empty; i++) step();
      mem_ack = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drain_timeout empty=%0b exp=1", empty); end
      checks++; if (wq_addr.size() !== 5) begin errors++; $display("FAIL full_count got=%0d exp=5", wq_addr.size()); end
      for (int i = 0; i < 5; i++) begin
         if (i < wq_addr.size()) begin
            checks++;
            if (wq_addr[i] !== ea[i] || wq_data[i] !== ed[i]) begin
               errors++; $display("FAIL full_order[%0d] got=%h/%h exp=%h/%h", i, wq_addr[i], wq_data[i], ea[i], ed[i]);
            end
         end
      end
   endtask

   task automatic test_wrap();
      logic [15:0] pat;
      int n;
      logic acc;
      pat = 16'b1011_0010_1110_0101;
      n = 0;
      wq_addr.delete(); wq_data.delete();
      for (int c = 0; c < 200 && !(n == 10 && empty); c++) begin
         if (n < 10) begin
            memwrite  = 1'b1;
            dataadr   = 32'h300 + 32'(4 * n);
            writedata = 32'h1000 + 32'(n);
         end else begin
            memwrite = 1'b0;
         end
         mem_ack = pat[c % 16];
         acc = memwrite && !stall;
         step();
         if (acc) n++;
      end
      memwrite = 1'b0; mem_ack = 1'b0;
      checks++; if (n !== 10 || empty !== 1'b1) begin errors++; $display("FAIL wrap_timeout pushed=%0d empty=%0b exp=10/1", n, empty); end
      checks++; if (wq_addr.size() !== 10) begin errors++; $display("FAIL wrap_count got=%0d exp=10", wq_addr.size()); end
      for (int i = 0; i < 10; i++) begin
         if (i < wq_addr.size()) begin
            checks++;
            if (wq_addr[i] !== 32'h300 + 32'(4 * i) || wq_data[i] !== 32'h1000 + 32'(i)) begin
               errors++; $display("FAIL wrap_order[%0d] got=%h/%h exp=%h/%h", i, wq_addr[i], wq_data[i], 32'h300 + 32'(4 * i), 32'h1000 + 32'(i));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      wq_addr.delete(); wq_data.delete();
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) push_one(32'h500 + 32'(4 * i), 32'h77 + 32'(i));
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_req_before got=%0b exp=1", mem_req); end
      #2; rst = 1'b0; #1;
      dataadr = 32'h500; #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_req got=%0b exp=0", mem_req); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got=%0b exp=1", empty); end
      checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL rstmid_fwd got=%0b exp=0", fwd_hit); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rstmid_addr got=%h exp=0", mem_addr); end
      #2; rst = 1'b1;
      mem_ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_idle[%0d] got=%0b exp=0", i, mem_req); end
      end
      mem_ack = 1'b0;
      checks++; if (wq_addr.size() !== 0) begin errors++; $display("FAIL rstmid_writes got=%0d exp=0", wq_addr.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_drain();
      test_forward();
      test_full_pop_push();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
